// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem read handshake, and IR/opcode capture.
// Optional ack-wait timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_done,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       ir_r;
    logic [31:0]       ir_s;
    logic              redirect_r;
    logic              redirect_s;
    logic              req_r;
    logic              done_r;
    logic              capture_s;
    logic              load_s;
    logic              timeout_s;
    logic              tmo_hit_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // The last permitted wait cycle ends the fetch with an error instead of waiting further.
    assign tmo_hit_s = (cnt_r == CNT_LAST);
    assign fetch_err = err_r;

    // Ack-wait counter: restarts on each new request, counts REQ cycles without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (capture_s) begin
            cnt_r <= '0;
        end else if ((state_r == REQ) && !imem_ack) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    logic tmo_unused_s;

    assign tmo_hit_s    = 1'b0;
    assign tmo_unused_s = (TIMEOUT_CYC > 32'sd0);
    assign fetch_err    = 1'b0;
`endif

    // Next-state logic for the IDLE -> REQ -> DONE fetch sequence.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        load_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fetch_start) begin
                    state_s   = REQ;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_s = DONE;
                    load_s  = 1'b1;
                end else if (tmo_hit_s) begin
                    state_s   = DONE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = REQ;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // PC, IR and redirect bookkeeping; a redirect during the fetch suppresses the +4 step.
    always_comb begin
        pc_s       = pc_r;
        ir_s       = ir_r;
        redirect_s = 1'b0;
        if (pc_write) begin
            pc_s = pc_target;
        end else if (load_s && !redirect_r) begin
            pc_s = addr_r + PC_STEP;
        end else begin
            pc_s = pc_r;
        end
        if (load_s) begin
            ir_s = imem_rdata;
        end else if (timeout_s) begin
            ir_s = 32'h0000_0000;
        end else begin
            ir_s = ir_r;
        end
        if ((state_r == REQ) && (state_s == REQ)) begin
            redirect_s = redirect_r | pc_write;
        end else begin
            redirect_s = 1'b0;
        end
    end

    // State and datapath registers; handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            addr_r     <= RESET_PC;
            ir_r       <= 32'h0000_0000;
            redirect_r <= 1'b0;
            req_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            addr_r     <= capture_s ? pc_r : addr_r;
            ir_r       <= ir_s;
            redirect_r <= redirect_s;
            req_r      <= (state_s == REQ);
            done_r     <= (state_s == DONE);
        end
    end

    assign imem_req   = req_r;
    assign busy       = req_r;
    assign imem_addr  = addr_r;
    assign ir         = ir_r;
    assign opcode     = ir_r[31:26];
    assign pc         = pc_r;
    assign fetch_done = done_r;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, 32: PC and instruction-memory address width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter TIMEOUT_CYC, 15: ack-wait limit in cycles (used only when FETCH_TIMEOUT_EN is defined).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port fetch_start, input, 1: Control is in IF; request one instruction fetch.
REQ-007 Port pc_write, input, 1: load pc_target into the PC (branch or jump taken).
REQ-008 Port pc_target, input, ADDR_W: redirect address.
REQ-009 Port imem_req, output, 1: instruction-memory read request.
REQ-010 Port imem_addr, output, ADDR_W: read address, held stable while imem_req=1.
REQ-011 Port imem_ack, input, 1: memory has read data valid this cycle.
REQ-012 Port imem_rdata, input, 32: instruction word.
REQ-013 Port ir, output, 32: instruction register.
REQ-014 Port opcode, output, 6: ir[31:26]; feeds Control.opcode.
REQ-015 Port pc, output, ADDR_W: current PC.
REQ-016 Port fetch_done, output, 1: one-cycle pulse when ir has been updated.
REQ-017 Port busy, output, 1: high in the REQ state.
REQ-018 Port fetch_err, output, 1: sticky timeout flag (tied 0 when FETCH_TIMEOUT_EN is not defined).

Function
REQ-019 The FSM SHALL have three states: IDLE (0), REQ (1), DONE (2).
REQ-020 IDLE with fetch_start=1 SHALL capture pc into addr_q and go to REQ on the next edge.
REQ-021 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal addr_q.
REQ-022 In REQ, imem_ack=1 SHALL load ir<=imem_rdata, go to DONE, and assert fetch_done for exactly the DONE cycle.
REQ-023 DONE SHALL return unconditionally to IDLE; minimum fetch latency is 3 cycles from fetch_start to opcode valid with zero-wait ack.
REQ-024 A fetch_start in REQ or DONE SHALL be ignored, with no queuing.
REQ-025 An imem_ack outside REQ SHALL be ignored.
REQ-026 On ack, pc SHALL become addr_q+4, wrapping modulo 2^ADDR_W, unless a redirect applies.
REQ-027 pc_write in any state SHALL set pc<=pc_target on that edge.
REQ-028 If pc_write is asserted in REQ, or coincides with ack, the target SHALL win and the ack SHALL NOT increment pc; a redirect_q flag holds this and clears on leaving REQ.
REQ-029 A pc_write in REQ SHALL NOT change imem_addr; the in-flight fetch completes at addr_q.
REQ-030 ir and opcode SHALL hold their values between fetches.

Reset
REQ-031 With rst_n=0, outputs SHALL take these values immediately, independent of clk: state IDLE, pc=RESET_PC, addr_q=RESET_PC, ir=0, imem_req=0, fetch_done=0, busy=0, fetch_err=0, redirect_q=0.
REQ-032 Reset during REQ SHALL abort the fetch; a later ack SHALL be ignored.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN defined: a counter SHALL clear on entering REQ and increment each REQ cycle without ack.
- At TIMEOUT_CYC without ack, the block SHALL load ir=0, set fetch_err=1 (sticky until reset), pulse fetch_done, go to DONE, and leave pc unchanged.
REQ-034 FETCH_TIMEOUT_EN undefined: REQ SHALL wait indefinitely, no counter SHALL exist, and fetch_err SHALL be 0.

Verification
REQ-035 Reset, then fetch_start with zero-wait ack and rdata=32'h2000_0005 -> imem_addr=0, opcode=6'h08, pc=4, one fetch_done pulse.
REQ-036 Ack delayed 3 cycles -> imem_req and imem_addr=4 held stable for 4 cycles, busy=1 throughout, pc=8 after ack.
REQ-037 pc_write with pc_target=32'h40 in REQ, ack 2 cycles later -> fetch completes at the old address, pc=32'h40 (not +4).
REQ-038 Repeated fetch_start in REQ, and a stray imem_ack in IDLE -> no extra fetch, ir unchanged.
REQ-039 rst_n low mid-REQ, with ack arriving during reset -> imem_req=0 immediately, pc=RESET_PC, ir=0.
REQ-040 FETCH_TIMEOUT_EN defined, no ack for 15 cycles -> fetch_err=1, ir=0, fetch_done pulse, pc unchanged.
